// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register carrying a control and a data bundle
// from stage N to stage N+1 under a valid/ready handshake.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   i_flush      synchronous kill of held entries and of the current input beat
//   i_in_valid   upstream beat present
//   o_in_ready   stage can accept a beat this cycle (a flop when SKID=1)
//   i_in_ctrl    upstream control bundle
//   i_in_data    upstream data bundle
//   o_out_valid  beat presented downstream
//   i_out_ready  downstream accepts this cycle
//   o_out_ctrl   control bundle, all-zero whenever o_out_valid=0
//   o_out_data   data bundle
//   o_occupancy  entries held (0..2)
//   o_stall_cnt  saturating count of cycles with valid output and no downstream ready
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 160,
    parameter int unsigned CTRL_W   = 12,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CLR_DATA = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occupancy,
    output logic [15:0]       o_stall_cnt
);

    typedef enum logic [1:0] {StEmpty, StMain, StBoth} state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic [CTRL_W-1:0]   r_main_ctrl, w_main_ctrl_d;
    logic [DATA_W-1:0]   r_main_data, w_main_data_d;
    logic [CTRL_W-1:0]   r_skid_ctrl, w_skid_ctrl_d;
    logic [DATA_W-1:0]   r_skid_data, w_skid_data_d;
    logic                r_in_ready;
    logic [15:0]         r_stall_cnt;

    logic w_out_valid;
    logic w_in_ready;
    logic w_in_acc;
    logic w_out_acc;

    assign w_out_valid = (r_state != StEmpty);
    // With the skid entry, in_ready is a flop so no combinational path runs back from
    // out_ready; without it, in_ready must look at out_ready to keep full throughput.
    assign w_in_ready  = (SKID != 0) ? r_in_ready : (!w_out_valid || i_out_ready);
    assign w_in_acc    = i_in_valid && w_in_ready;
    assign w_out_acc   = w_out_valid && i_out_ready;

    always_comb begin
        w_state_d     = r_state;
        w_main_ctrl_d = r_main_ctrl;
        w_main_data_d = r_main_data;
        w_skid_ctrl_d = r_skid_ctrl;
        w_skid_data_d = r_skid_data;
        if (i_flush) begin
            // Flush wins over every transfer, including the beat on the input this cycle.
            w_state_d     = StEmpty;
            w_main_ctrl_d = '0;
            w_skid_ctrl_d = '0;
            if (CLR_DATA != 0) begin
                w_main_data_d = '0;
                w_skid_data_d = '0;
            end
        end else begin
            unique case (r_state)
                StEmpty: begin
                    if (w_in_acc) begin
                        w_state_d     = StMain;
                        w_main_ctrl_d = i_in_ctrl;
                        w_main_data_d = i_in_data;
                    end
                end
                StMain: begin
                    if (w_in_acc && w_out_acc) begin
                        w_main_ctrl_d = i_in_ctrl;
                        w_main_data_d = i_in_data;
                    end else if (w_in_acc && (SKID != 0)) begin
                        // Younger beat parks in the skid entry behind main.
                        w_state_d     = StBoth;
                        w_skid_ctrl_d = i_in_ctrl;
                        w_skid_data_d = i_in_data;
                    end else if (w_out_acc) begin
                        w_state_d = StEmpty;
                    end
                end
                StBoth: begin
                    if (w_out_acc) begin
                        w_state_d     = StMain;
                        w_main_ctrl_d = r_skid_ctrl;
                        w_main_data_d = r_skid_data;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= StEmpty;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_in_ready  <= 1'b1;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_d;
            r_main_ctrl <= w_main_ctrl_d;
            r_main_data <= w_main_data_d;
            r_skid_ctrl <= w_skid_ctrl_d;
            r_skid_data <= w_skid_data_d;
            r_in_ready  <= (w_state_d != StBoth);
            if (w_out_valid && !i_out_ready && !i_flush && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        o_occupancy = 2'd0;
        unique case (r_state)
            StEmpty: o_occupancy = 2'd0;
            StMain:  o_occupancy = 2'd1;
            StBoth:  o_occupancy = 2'd2;
            default: o_occupancy = 2'd0;
        endcase
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    // Bubbles carry zero control so a stale RegWrite/MemWrite never leaks downstream.
    assign o_out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign o_out_data  = r_main_data;
    assign o_stall_cnt = r_stall_cnt;

endmodule
